pulse_scan_sequencer: RTL and testbench
=======================================

// Module: pulse_scan_sequencer
// PURPOSE
//  Sequences the pulse generator through a delay scan: steps the inter-pulse delay (del) over
//  n_points values, holding each for DISCARD settle shots plus n_shots counted shots.
//  Drives the generator's del and cp inputs. Counts shots on the generator's sync_on trigger.
//  Sits between the LabView-loaded scan registers and the pulse generator.
//  Emits per-shot acquisition strobes for the averager.
// PARAMETERS
//  DISCARD  2  shots ignored after each del change (covers the generator's 2-stage param sync)
//  IDX_W    16 width of point/shot counters and of n_points/n_shots
// PORTS
//  clk_pll    in  1      200 MHz PLL clock; sole clock
//  reset      in  1      synchronous, active-high reset
//  start      in  1      level; sampled only in IDLE; begins a scan
//  abort      in  1      level; ends scan next cycle from any state
//  del_start  in  32     delay of point 0, clk_pll cycles
//  del_step   in  32     delay increment per point, unsigned
//  n_points   in  IDX_W  number of scan points
//  n_shots    in  IDX_W  counted shots per point
//  sync_on    in  1      scope trigger from pulse generator; rising edge = shot boundary
//  del        out 32     delay to generator
//  cp         out 1      generator pulsed-mode enable
//  busy       out 1      high from ARM through LAST
//  acq_valid  out 1      1-cycle strobe per counted shot
//  point_idx  out IDX_W  current point, 0-based
//  shot_idx   out IDX_W  index of shot flagged by acq_valid
//  done       out 1      1-cycle strobe at normal scan completion
//  err        out 1      sticky: del overflowed 32 bits; cleared by next accepted start
// BEHAVIOUR
//  Reset: state=IDLE; del=0, cp=0, busy=0, acq_valid=0, done=0, err=0, point_idx=0, shot_idx=0.
//  Reset mid-scan: same values next cycle; no done strobe.
//  All outputs registered. Edge detect: sync_q<=sync_on; edge = sync_on & ~sync_q.
//  On start, inputs snapshot to internal registers; later input changes are ignored until IDLE.
//  States:
//   IDLE  : start&~abort -> if n_points==0 or n_shots==0 -> LAST (cp stays 0)
//            else ARM. Accepting start clears err.
//   ARM   : 1 cycle. del<=del_start, cp<=1, busy<=1, point_idx<=0; -> SETTLE with discard cnt=0.
//   SETTLE: each edge increments discard cnt; at DISCARD edges -> ACQ, shot cnt=0.
//            DISCARD=0 goes straight to ACQ.
//   ACQ   : each edge: acq_valid=1 next cycle with shot_idx=shot cnt; cnt++.
//            After the n_shots-th edge: if point_idx==n_points-1 -> LAST.
//            Otherwise del<=del+del_step and point_idx++.
//            If that add carries out of bit 31: err<=1 -> LAST.
//            Else -> SETTLE.
//   LAST  : 1 cycle. cp<=0, busy<=0, done<=1 unless entered on err; -> IDLE.
//  del holds last value in IDLE (not cleared) so the generator stays stable.
//  Latency: start->cp high 2 cycles (IDLE->ARM->register). edge->acq_valid 1 cycle.
//  Last shot edge -> done 2 cycles.
//  abort: highest priority. Any state -> IDLE next cycle, cp=0, busy=0, no done, no acq_valid.
//   If coincident with an edge, the edge is dropped.
//  start while busy: ignored. sync_on high at ARM exit: not an edge until it falls and rises again.
//  Counters compare with ==, never wrap; n_points=n_shots=2^IDX_W-1 must complete.
// TESTING
//  Test 1 (normal scan). Stimulus: del_start=100, del_step=20, n_points=3, n_shots=4, DISCARD=2, 22 sync edges.
//   Required: del=100,120,140; 12 acq_valid strobes with shot_idx 0..3 per point; done once; cp falls with done.
//  Test 2 (zero points). Stimulus: n_points=0.
//   Required: done 2 cycles after start, cp never high, no acq_valid.
//  Test 3 (abort mid-scan). Stimulus: abort on the same cycle as a sync edge in ACQ of point 1.
//   Required: no acq_valid for that edge, cp=0 and busy=0 next cycle, done never asserted, del holds 120.
//  Test 4 (overflow). Stimulus: del_start=32'hFFFF_FFF0, del_step=32'h20, n_points=2.
//   Required: err=1 after point 0 shots; scan ends without done; next start clears err.
//  Test 5 (reset and retrigger). Stimulus: reset asserted in SETTLE; then start held high while busy.
//   Required: all outputs return to reset values next cycle; the held start launches exactly one scan, no retrigger.
//  Test 6 (sync high on entry). Stimulus: sync_on already high during ARM.
//   Required: it is not counted; counting begins at the next rising edge.

Source files
------------

// File: rtl/pulse_scan_sequencer.sv
// Delay-scan sequencer for the pulse generator: steps del over n_points values and
// strobes one acquisition per counted sync_on shot after DISCARD settle shots per point.
//
// state  | meaning
// IDLE   | waiting for start; del holds its last value
// ARM    | loads del_start, raises cp and busy
// SETTLE | discards shots while the generator absorbs the new del
// ACQ    | counts shots and strobes acq_valid; steps del after the last shot of a point
// LAST   | drops cp and busy, pulses done unless the scan ended on overflow
module pulse_scan_sequencer #(
    parameter int DISCARD = 2,
    parameter int IDX_W   = 16
) (
    input  logic             clk_pll,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      del_start,
    input  logic [31:0]      del_step,
    input  logic [IDX_W-1:0] n_points,
    input  logic [IDX_W-1:0] n_shots,
    input  logic             sync_on,
    output logic [31:0]      del,
    output logic             cp,
    output logic             busy,
    output logic             acq_valid,
    output logic [IDX_W-1:0] point_idx,
    output logic [IDX_W-1:0] shot_idx,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SETTLE,
        S_ACQ,
        S_LAST
    } state_t;

    localparam logic [IDX_W-1:0] DISCARD_LAST = IDX_W'((DISCARD > 0) ? DISCARD - 1 : 0);
    // With no settle shots the sequencer goes straight from a del change to counting.
    localparam state_t AFTER_STEP = (DISCARD == 0) ? S_ACQ : S_SETTLE;

    state_t           state, state_nx;
    logic             sync_q;
    logic             sync_edge;
    logic [31:0]      del_start_r, del_start_nx;
    logic [31:0]      del_step_r, del_step_nx;
    logic [IDX_W-1:0] n_points_r, n_points_nx;
    logic [IDX_W-1:0] n_shots_r, n_shots_nx;
    logic [IDX_W-1:0] discard_cnt, discard_cnt_nx;
    logic [IDX_W-1:0] shot_cnt, shot_cnt_nx;
    logic [31:0]      del_nx;
    logic             cp_nx, busy_nx, acq_valid_nx, done_nx, err_nx;
    logic [IDX_W-1:0] point_idx_nx, shot_idx_nx;
    logic [32:0]      del_sum;

    assign sync_edge = sync_on & ~sync_q;
    assign del_sum   = {1'b0, del} + {1'b0, del_step_r};

    always_ff @(posedge clk_pll) begin
        if (reset) begin
            state       <= S_IDLE;
            sync_q      <= 1'b0;
            del_start_r <= '0;
            del_step_r  <= '0;
            n_points_r  <= '0;
            n_shots_r   <= '0;
            discard_cnt <= '0;
            shot_cnt    <= '0;
            del         <= '0;
            cp          <= 1'b0;
            busy        <= 1'b0;
            acq_valid   <= 1'b0;
            point_idx   <= '0;
            shot_idx    <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nx;
            sync_q      <= sync_on;
            del_start_r <= del_start_nx;
            del_step_r  <= del_step_nx;
            n_points_r  <= n_points_nx;
            n_shots_r   <= n_shots_nx;
            discard_cnt <= discard_cnt_nx;
            shot_cnt    <= shot_cnt_nx;
            del         <= del_nx;
            cp          <= cp_nx;
            busy        <= busy_nx;
            acq_valid   <= acq_valid_nx;
            point_idx   <= point_idx_nx;
            shot_idx    <= shot_idx_nx;
            done        <= done_nx;
            err         <= err_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        del_start_nx   = del_start_r;
        del_step_nx    = del_step_r;
        n_points_nx    = n_points_r;
        n_shots_nx     = n_shots_r;
        discard_cnt_nx = discard_cnt;
        shot_cnt_nx    = shot_cnt;
        del_nx         = del;
        cp_nx          = cp;
        busy_nx        = busy;
        acq_valid_nx   = 1'b0;
        point_idx_nx   = point_idx;
        shot_idx_nx    = shot_idx;
        done_nx        = 1'b0;
        err_nx         = err;

        if (abort) begin
            state_nx = S_IDLE;
            cp_nx    = 1'b0;
            busy_nx  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        del_start_nx = del_start;
                        del_step_nx  = del_step;
                        n_points_nx  = n_points;
                        n_shots_nx   = n_shots;
                        err_nx       = 1'b0;
                        if ((n_points == '0) || (n_shots == '0)) state_nx = S_LAST;
                        else                                     state_nx = S_ARM;
                    end
                end
                S_ARM: begin
                    del_nx         = del_start_r;
                    cp_nx          = 1'b1;
                    busy_nx        = 1'b1;
                    point_idx_nx   = '0;
                    discard_cnt_nx = '0;
                    shot_cnt_nx    = '0;
                    state_nx       = AFTER_STEP;
                end
                S_SETTLE: begin
                    if (sync_edge) begin
                        if (discard_cnt == DISCARD_LAST) begin
                            shot_cnt_nx = '0;
                            state_nx    = S_ACQ;
                        end else begin
                            discard_cnt_nx = discard_cnt + 1'b1;
                        end
                    end
                end
                S_ACQ: begin
                    if (sync_edge) begin
                        acq_valid_nx = 1'b1;
                        shot_idx_nx  = shot_cnt;
                        if (shot_cnt == n_shots_r - 1'b1) begin
                            if (point_idx == n_points_r - 1'b1) begin
                                state_nx = S_LAST;
                            end else if (del_sum[32]) begin
                                // del is left at the last good value so the generator stays stable
                                err_nx   = 1'b1;
                                state_nx = S_LAST;
                            end else begin
                                del_nx         = del_sum[31:0];
                                point_idx_nx   = point_idx + 1'b1;
                                discard_cnt_nx = '0;
                                shot_cnt_nx    = '0;
                                state_nx       = AFTER_STEP;
                            end
                        end else begin
                            shot_cnt_nx = shot_cnt + 1'b1;
                        end
                    end
                end
                S_LAST: begin
                    cp_nx    = 1'b0;
                    busy_nx  = 1'b0;
                    done_nx  = ~err;
                    state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_scan_sequencer.sv
// Directed bench for pulse_scan_sequencer: normal scan, zero points, abort, overflow,
// reset mid-scan with held start, and sync_on already high at scan entry.
`timescale 1ns/1ps
module tb_pulse_scan_sequencer;

    logic        clk_pll = 1'b0;
    logic        reset, start, abort, sync_on;
    logic [31:0] del_start, del_step;
    logic [15:0] n_points, n_shots;
    logic [31:0] del;
    logic        cp, busy, acq_valid, done, err;
    logic [15:0] point_idx, shot_idx;

    int checks = 0;
    int errors = 0;

    int          acq_cnt = 0;
    int          done_cnt = 0;
    int          busy_rise = 0;
    int          cp_high = 0;
    logic        busy_q = 1'b0;
    logic        cp_at_done = 1'b1;
    logic [15:0] acq_shot [0:127];
    logic [15:0] acq_point[0:127];
    logic [31:0] acq_del  [0:127];

    int base_acq, base_done, base_cp, base_busy;

    pulse_scan_sequencer #(.DISCARD(2), .IDX_W(16)) dut (
        .clk_pll  (clk_pll),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .del_start(del_start),
        .del_step (del_step),
        .n_points (n_points),
        .n_shots  (n_shots),
        .sync_on  (sync_on),
        .del      (del),
        .cp       (cp),
        .busy     (busy),
        .acq_valid(acq_valid),
        .point_idx(point_idx),
        .shot_idx (shot_idx),
        .done     (done),
        .err      (err)
    );

    always #2.5 clk_pll = ~clk_pll;

    always @(negedge clk_pll) begin
        if (acq_valid && acq_cnt < 128) begin
            acq_shot[acq_cnt]  = shot_idx;
            acq_point[acq_cnt] = point_idx;
            acq_del[acq_cnt]   = del;
        end
        if (acq_valid) acq_cnt = acq_cnt + 1;
        if (done) begin
            done_cnt   = done_cnt + 1;
            cp_at_done = cp;
        end
        if (cp) cp_high = cp_high + 1;
        if (busy && !busy_q) busy_rise = busy_rise + 1;
        busy_q = busy;
    end

    task automatic tick;
        @(posedge clk_pll);
        #1;
    endtask

    task automatic shot;
        sync_on = 1'b1;
        tick();
        tick();
        sync_on = 1'b0;
        tick();
        tick();
    endtask

    task automatic shots(input int n);
        for (int i = 0; i < n; i++) shot();
    endtask

    task automatic start_scan;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; sync_on = 1'b0;
        del_start = 32'd0; del_step = 32'd0; n_points = 16'd0; n_shots = 16'd0;
        tick();
        tick();
        chk("rst_del", del, 32'd0);
        chk("rst_cp", {31'd0, cp}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_acq", {31'd0, acq_valid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_point", {16'd0, point_idx}, 32'd0);
        chk("rst_shot", {16'd0, shot_idx}, 32'd0);
        reset = 1'b0;
        tick();

        // Test 1: normal scan, 22 edges (18 used, 4 after completion)
        del_start = 32'd100; del_step = 32'd20; n_points = 16'd3; n_shots = 16'd4;
        base_acq = acq_cnt; base_done = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_cp_arm", {31'd0, cp}, 32'd0);
        tick();
        chk("t1_cp_on", {31'd0, cp}, 32'd1);
        chk("t1_busy_on", {31'd0, busy}, 32'd1);
        chk("t1_del0", del, 32'd100);
        del_start = 32'd9999; n_points = 16'd1;
        shots(22);
        chk("t1_acq_cnt", acq_cnt - base_acq, 32'd12);
        chk("t1_done_cnt", done_cnt - base_done, 32'd1);
        chk("t1_cp_at_done", {31'd0, cp_at_done}, 32'd0);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            chk("t1_shot_idx", {16'd0, acq_shot[base_acq + i]}, 32'(i % 4));
            if (i % 4 == 0) begin
                chk("t1_point_idx", {16'd0, acq_point[base_acq + i]}, 32'(i / 4));
                chk("t1_del", acq_del[base_acq + i], 32'(100 + 20 * (i / 4)));
            end
        end

        // Test 2: zero points
        n_points = 16'd0; n_shots = 16'd4;
        base_acq = acq_cnt; base_cp = cp_high;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_done_early", {31'd0, done}, 32'd0);
        tick();
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_cp", {31'd0, cp}, 32'd0);
        tick();
        chk("t2_done_once", {31'd0, done}, 32'd0);
        chk("t2_cp_never", cp_high - base_cp, 32'd0);
        chk("t2_no_acq", acq_cnt - base_acq, 32'd0);
        chk("t2_del_hold", del, 32'd140);

        // Test 3: abort coincident with an edge in ACQ of point 1
        del_start = 32'd100; del_step = 32'd20; n_points = 16'd3; n_shots = 16'd4;
        base_acq = acq_cnt; base_done = done_cnt;
        start_scan();
        shots(9);
        chk("t3_acq_before", acq_cnt - base_acq, 32'd5);
        sync_on = 1'b1;
        abort = 1'b1;
        tick();
        chk("t3_acq_dropped", {31'd0, acq_valid}, 32'd0);
        chk("t3_cp", {31'd0, cp}, 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        chk("t3_del", del, 32'd120);
        abort = 1'b0;
        sync_on = 1'b0;
        tick();
        tick();
        chk("t3_acq_after", acq_cnt - base_acq, 32'd5);
        chk("t3_no_done", done_cnt - base_done, 32'd0);

        // Test 4: del overflow
        del_start = 32'hFFFF_FFF0; del_step = 32'h20; n_points = 16'd2; n_shots = 16'd2;
        base_acq = acq_cnt; base_done = done_cnt;
        start_scan();
        chk("t4_del0", del, 32'hFFFF_FFF0);
        shots(4);
        chk("t4_err", {31'd0, err}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_cp", {31'd0, cp}, 32'd0);
        chk("t4_no_done", done_cnt - base_done, 32'd0);
        chk("t4_acq", acq_cnt - base_acq, 32'd2);
        del_start = 32'd7; n_points = 16'd1; n_shots = 16'd1;
        base_done = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_err_clr", {31'd0, err}, 32'd0);
        tick();
        shots(3);
        chk("t4_done_next", done_cnt - base_done, 32'd1);
        chk("t4_err_stays", {31'd0, err}, 32'd0);

        // Test 5: reset in SETTLE of point 1, then start held while busy
        del_start = 32'd50; del_step = 32'd5; n_points = 16'd2; n_shots = 16'd2;
        start_scan();
        shots(5);
        chk("t5_pre_point", {16'd0, point_idx}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_del", del, 32'd0);
        chk("t5_cp", {31'd0, cp}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_point", {16'd0, point_idx}, 32'd0);
        chk("t5_shot", {16'd0, shot_idx}, 32'd0);
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_acq", {31'd0, acq_valid}, 32'd0);
        chk("t5_err", {31'd0, err}, 32'd0);
        base_acq = acq_cnt; base_done = done_cnt; base_busy = busy_rise;
        start = 1'b1;
        tick();
        tick();
        shots(2);
        start = 1'b0;
        shots(6);
        tick();
        tick();
        chk("t5_one_done", done_cnt - base_done, 32'd1);
        chk("t5_acq_cnt", acq_cnt - base_acq, 32'd4);
        chk("t5_one_scan", busy_rise - base_busy, 32'd1);
        chk("t5_idle", {31'd0, busy}, 32'd0);

        // Test 6: sync_on already high across ARM
        del_start = 32'd10; n_points = 16'd1; n_shots = 16'd1;
        base_acq = acq_cnt; base_done = done_cnt;
        sync_on = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        sync_on = 1'b0;
        tick();
        tick();
        shots(2);
        chk("t6_not_counted", acq_cnt - base_acq, 32'd0);
        chk("t6_still_busy", {31'd0, busy}, 32'd1);
        shots(1);
        chk("t6_acq", acq_cnt - base_acq, 32'd1);
        chk("t6_done", done_cnt - base_done, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
